// File: rtl/pulse_counter_param_if.sv
// pulse_counter_param_if
// Bundles the event input, control inputs and status outputs of
// pulse_counter_param. Clock and reset stay outside as plain ports.
//   master : drives pulse_in/enable/up_down/clear/load/load_value, observes status
//   slave  : the counter itself; consumes controls, drives count and flags
interface pulse_counter_param_if #(
  parameter int WIDTH = 4
);
  logic             pulse_in;
  logic             enable;
  logic             up_down;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] count;
  logic             pulse_det;
  logic             at_max;
  logic             at_zero;
  logic             overflow;
  logic             underflow;

  modport master (
    output pulse_in, enable, up_down, clear, load, load_value,
    input  count, pulse_det, at_max, at_zero, overflow, underflow
  );

  modport slave (
    input  pulse_in, enable, up_down, clear, load, load_value,
    output count, pulse_det, at_max, at_zero, overflow, underflow
  );
endinterface

// File: rtl/pulse_counter_param.sv
// pulse_counter_param
// Counts qualified edges of an asynchronous pulse input. The input is passed
// through a SYNC_STAGES-deep synchronizer, edge-detected against a history
// flop, and each detected edge (rising, falling or both per EDGE_SEL) moves a
// WIDTH-bit up/down counter that either wraps or saturates at its limits.
// Ports:
//   clock   : system clock, all state on rising edge
//   reset_n : asynchronous active-low reset
//   bus     : slave side of pulse_counter_param_if
//             (pulse_in, enable, up_down, clear, load, load_value in;
//              count, pulse_det, at_max, at_zero, overflow, underflow out)
module pulse_counter_param #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_SEL    = 0,
  parameter int SATURATE    = 0
) (
  input  logic                    clock,
  input  logic                    reset_n,
  pulse_counter_param_if.slave    bus
);

  localparam logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_VAL  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [1:0]       EDGE_MODE = EDGE_SEL[1:0];
  localparam logic             SAT_EN    = (SATURATE != 0);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic [WIDTH-1:0]       count_q, count_d;
  logic                   pulse_det_q, pulse_det_d;
  logic                   overflow_q, overflow_d;
  logic                   underflow_q, underflow_d;

  logic sync_s;
  logic rise_s;
  logic fall_s;
  logic det_s;

  // Synchronizer shift and edge detection on the synchronized level.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], bus.pulse_in};
    sync_s = sync_q[SYNC_STAGES-1];
    hist_d = sync_s;
    rise_s = sync_s & ~hist_q;
    fall_s = ~sync_s & hist_q;
    case (EDGE_MODE)
      2'd0:    det_s = rise_s;
      2'd1:    det_s = fall_s;
      2'd2:    det_s = rise_s | fall_s;
      default: det_s = rise_s;
    endcase
  end

  // Next count and sticky flags; clear beats load beats counting.
  always_comb begin
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    pulse_det_d = det_s;
    if (bus.clear) begin
      count_d     = ZERO_VAL;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else if (bus.load) begin
      count_d = bus.load_value;
    end else if (det_s && bus.enable) begin
      if (bus.up_down) begin
        if (count_q == MAX_VAL) begin
          overflow_d = 1'b1;
          if (SAT_EN) begin
            count_d = count_q;
          end else begin
            count_d = ZERO_VAL;
          end
        end else begin
          count_d = count_q + ONE_VAL;
        end
      end else begin
        if (count_q == ZERO_VAL) begin
          underflow_d = 1'b1;
          if (SAT_EN) begin
            count_d = count_q;
          end else begin
            count_d = MAX_VAL;
          end
        end else begin
          count_d = count_q - ONE_VAL;
        end
      end
    end else begin
      count_d = count_q;
    end
  end

  // State registers; history restarts at 0 so a level held high through
  // reset release is seen as a fresh rising edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q      <= {SYNC_STAGES{1'b0}};
      hist_q      <= 1'b0;
      count_q     <= ZERO_VAL;
      pulse_det_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      hist_q      <= hist_d;
      count_q     <= count_d;
      pulse_det_q <= pulse_det_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.count     = count_q;
  assign bus.pulse_det = pulse_det_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
  assign bus.at_max    = (count_q == MAX_VAL);
  assign bus.at_zero   = (count_q == ZERO_VAL);

endmodule

// File: tb/tb_pulse_counter_param.sv
// tb_pulse_counter_param
// Four counter instances share one stimulus: 0 = rising/wrap, 1 = rising/
// saturate, 2 = both edges/wrap, 3 = falling/wrap. Stimulus pushes the
// expected (count, flags, cycle) for the selected instance; a monitor pops
// and compares whenever that instance strobes pulse_det.
module tb_pulse_counter_param;

  typedef struct {
    logic [3:0] cnt;
    logic       ov;
    logic       un;
    int         cyc;
  } exp_t;

  logic       clock;
  logic       reset_n;
  logic       pulse_in;
  logic       enable;
  logic       up_down;
  logic       clear;
  logic       load;
  logic [3:0] load_value;

  logic [3:0] cnt_o [4];
  logic       pd_o  [4];
  logic       am_o  [4];
  logic       az_o  [4];
  logic       ov_o  [4];
  logic       un_o  [4];

  exp_t exp_q[$];
  int   checks;
  int   failures;
  int   cyc;
  int   sel;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    pulse_counter_param_if #(.WIDTH(4)) bus ();
    assign bus.pulse_in   = pulse_in;
    assign bus.enable     = enable;
    assign bus.up_down    = up_down;
    assign bus.clear      = clear;
    assign bus.load       = load;
    assign bus.load_value = load_value;
    pulse_counter_param #(
      .WIDTH(4),
      .SYNC_STAGES(2),
      .EDGE_SEL((g == 2) ? 2 : ((g == 3) ? 1 : 0)),
      .SATURATE((g == 1) ? 1 : 0)
    ) dut (
      .clock(clock),
      .reset_n(reset_n),
      .bus(bus)
    );
    assign cnt_o[g] = bus.count;
    assign pd_o[g]  = bus.pulse_det;
    assign am_o[g]  = bus.at_max;
    assign az_o[g]  = bus.at_zero;
    assign ov_o[g]  = bus.overflow;
    assign un_o[g]  = bus.underflow;
  end

  task automatic chk(input string name, input int act, input int req);
    checks = checks + 1;
    if (act != req) begin
      failures = failures + 1;
      $display("FAIL %s dut=%0d actual=%0d required=%0d t=%0t", name, sel, act, req, $time);
    end
  endtask

  // Monitor: every strobe of the selected instance must match the next expectation.
  always @(negedge clock) begin
    exp_t e;
    if (reset_n && pd_o[sel]) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("count", int'(cnt_o[sel]), int'(e.cnt));
        chk("overflow", int'(ov_o[sel]), int'(e.ov));
        chk("underflow", int'(un_o[sel]), int'(e.un));
        chk("at_max", int'(am_o[sel]), (e.cnt == 4'hF) ? 1 : 0);
        chk("at_zero", int'(az_o[sel]), (e.cnt == 4'h0) ? 1 : 0);
        chk("latency_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic push_exp(input logic [3:0] c, input logic ov, input logic un);
    exp_t e;
    e.cnt = c;
    e.ov  = ov;
    e.un  = un;
    e.cyc = cyc + 3;
    exp_q.push_back(e);
  endtask

  // Drive a new pulse_in level, optionally expect a strobe, optionally hit
  // clear+load on the update edge, then hold the level for three cycles.
  task automatic edge_to(input logic lvl, input bit ev, input logic [3:0] c,
                         input logic ov, input logic un, input bit ctl);
    @(negedge clock);
    pulse_in = lvl;
    if (ev) push_exp(c, ov, un);
    @(negedge clock);
    @(negedge clock);
    if (ctl) begin
      clear = 1'b1;
      load = 1'b1;
      load_value = 4'h7;
    end
    @(negedge clock);
    clear = 1'b0;
    load = 1'b0;
  endtask

  task automatic do_load(input logic [3:0] v);
    @(negedge clock);
    load = 1'b1;
    load_value = v;
    @(negedge clock);
    load = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  task automatic drain(input string name);
    idle(2);
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0; sel = 0;
    reset_n = 1'b0; pulse_in = 1'b0; enable = 1'b1; up_down = 1'b1;
    clear = 1'b0; load = 1'b0; load_value = 4'h0;
    #1;
    chk("rst_count", int'(cnt_o[0]), 0);
    chk("rst_pulse_det", int'(pd_o[0]), 0);
    chk("rst_overflow", int'(ov_o[0]), 0);
    chk("rst_underflow", int'(un_o[0]), 0);
    chk("rst_at_zero", int'(az_o[0]), 1);
    idle(2);
    reset_n = 1'b1;
    idle(2);

    // 1: four rising pulses count up 1..4
    sel = 0;
    edge_to(1'b1, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0); edge_to(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    edge_to(1'b1, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0); edge_to(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    edge_to(1'b1, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0); edge_to(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    edge_to(1'b1, 1'b1, 4'h4, 1'b0, 1'b0, 1'b0); edge_to(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    drain("t1_drain");

    // 2: wrap from E through F, 0, 1 with sticky overflow
    do_load(4'hE);
    idle(1);
    chk("t2_load_at_max", int'(am_o[0]), 0);
    edge_to(1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0); edge_to(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    edge_to(1'b1, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0); edge_to(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    edge_to(1'b1, 1'b1, 4'h1, 1'b1, 1'b0, 1'b0); edge_to(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    drain("t2_drain");

    // 3: saturating down-count from 1 holds at 0 with underflow
    sel = 1;
    do_clear();
    up_down = 1'b0;
    do_load(4'h1);
    edge_to(1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0); edge_to(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    edge_to(1'b1, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0); edge_to(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    edge_to(1'b1, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0); edge_to(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    drain("t3_drain");
    do_clear();
    idle(1);
    chk("t3_clr_count", int'(cnt_o[1]), 0);
    chk("t3_clr_underflow", int'(un_o[1]), 0);
    up_down = 1'b1;
    idle(1);

    // 4: clear+load on the detect cycle -> cleared; disabled edges dropped
    sel = 0;
    edge_to(1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1); edge_to(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    enable = 1'b0;
    edge_to(1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0); edge_to(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    edge_to(1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0); edge_to(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    enable = 1'b1;
    drain("t4_drain");

    // 5a: both edges counted -> 6 after three pulses
    sel = 2;
    do_clear();
    edge_to(1'b1, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0); edge_to(1'b0, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0);
    edge_to(1'b1, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0); edge_to(1'b0, 1'b1, 4'h4, 1'b0, 1'b0, 1'b0);
    edge_to(1'b1, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0); edge_to(1'b0, 1'b1, 4'h6, 1'b0, 1'b0, 1'b0);
    drain("t5a_drain");

    // 5b: falling edges only -> 3, timed from each fall
    sel = 3;
    do_clear();
    edge_to(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0); edge_to(1'b0, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
    edge_to(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0); edge_to(1'b0, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0);
    edge_to(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0); edge_to(1'b0, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0);
    drain("t5b_drain");

    // 6: async reset mid-count, then release with pulse_in held high
    sel = 0;
    do_clear();
    do_load(4'hF);
    edge_to(1'b1, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0); edge_to(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    drain("t6_pre_drain");
    do_load(4'h9);
    idle(1);
    chk("t6_pre_count", int'(cnt_o[0]), 9);
    chk("t6_pre_overflow", int'(ov_o[0]), 1);
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_async_count", int'(cnt_o[0]), 0);
    chk("t6_async_overflow", int'(ov_o[0]), 0);
    chk("t6_async_underflow", int'(un_o[0]), 0);
    pulse_in = 1'b1;
    @(negedge clock);
    reset_n = 1'b1;
    push_exp(4'h1, 1'b0, 1'b0);
    idle(6);
    chk("t6_final_count", int'(cnt_o[0]), 1);
    drain("t6_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
